// File: rtl/simplecoder_pkg.sv
// Shared constants, width helper and state naming for the round-robin select encoder.
package simplecoder_pkg;

  localparam int DEF_N = 4;

  // Select-code width for n request lines; never narrower than one bit.
  function automatic int clog2w(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } enc_state_e;

endpackage

// File: rtl/simpleencoder_rr_pick.sv
// Combinational round-robin scan: first set bit of vec at or after ptr, wrapping at N-1.
module rr_pick
  import simplecoder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = clog2w(N)
) (
  input  logic [0:N-1] vec,
  input  logic [0:W-1] ptr,
  output logic         any,
  output logic [0:W-1] idx
);

  logic [0:N-1] rot;
  int           hit;

  // ptr < N and offset < N, so a single conditional subtract keeps the index in range.
  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = vec[W'(wrap(int'(ptr) + i))];
    end
    any = |rot;
    hit = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) hit = i;
    end
    idx = W'(wrap(int'(ptr) + hit));
  end

endmodule

// File: rtl/simpleencoder_rr.sv
// Round-robin encoder: accumulates request lines into a pending vector and emits one
// select code per valid/ready transfer, resuming the scan just past the last grant.
module simpleencoder_rr
  import simplecoder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = clog2w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:N-1] req,
  input  logic         ready,
  output logic [0:W-1] sel_out,
  output logic         valid,
  output logic [0:N-1] pending
);

  enc_state_e   state_q, state_d;
  logic [0:N-1] pending_q, pending_d;
  logic [0:W-1] ptr_q, ptr_d;
  logic [0:W-1] sel_q, sel_d;
  logic [0:N-1] load_mask;
  logic         load;
  logic         pick_any;
  logic [0:W-1] pick;

  rr_pick #(.N(N), .W(W)) u_pick (
    .vec (pending_q),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      pending_q <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
    end
  end

  always_comb begin
    load      = (state_q == EMPTY) || ready;
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    load_mask = '0;
    if (load) begin
      if (pick_any) begin
        state_d         = HOLD;
        sel_d           = pick;
        ptr_d           = (pick == W'(N - 1)) ? '0 : pick + W'(1);
        load_mask[pick] = 1'b1;
      end else begin
        state_d = EMPTY;
      end
    end
    // A request arriving on the bit being granted re-arms it for a later grant.
    pending_d = (pending_q & ~load_mask) | req;
  end

  always_comb begin
    sel_out = sel_q;
    valid   = (state_q == HOLD);
    pending = pending_q;
  end

endmodule
